multicycle_ctrl_hs: RTL and testbench
=====================================

Name: multicycle_ctrl_hs

Overview:
Parametrised multicycle control unit for the RV32I subset datapath. Next generation of the IF/ID/EX/MEM/WB control FSM, with these additions:
- instruction-memory and data-memory ready handshakes, with wait states;
- an internal instruction register;
- BNE/BLT/BGE branches;
- illegal-instruction and memory-timeout trap state;
- retired-instruction counter.
Sits between the instruction/data memories and the existing datapath, and drives all datapath control strobes.

Parameters:
MEM_TIMEOUT, 16, max MEM-state wait cycles before trap; 0 disables the timeout.
CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
instr  in  32  instruction word from instruction memory
instr_valid  in  1  instruction memory has instr ready
dReady  in  1  data memory access complete
Zero  in  1  ALU result-is-zero flag
ir  out  32  latched instruction register, feeds datapath decode
ALUCtrl  out  4  ALU operation code
ALUSrc  out  1  1 = immediate operand B
MemRead  out  1  data memory read strobe
MemWrite  out  1  data memory write strobe
MemToReg  out  1  1 = writeback from memory
RegWrite  out  1  register file write enable
loadPC  out  1  PC register load enable
PCSrc  out  1  1 = branch target
trap  out  1  sticky error flag
trap_cause  out  2  00 none, 01 illegal instr, 10 mem timeout
state  out  3  current FSM state (debug)
instret  out  CNT_WIDTH  retired instruction count

Behaviour:
- Reset (rst=0, async):
  - state=IF, ir=0, instret=0, trap=0, trap_cause=00, wait counter=0.
  - All strobes 0.
  - ALUCtrl=0010, ALUSrc=0.
- States: IF=000, ID=001, EX=010, MEM=011, WB=100, TRAP=101.
- IF:
  - Hold while instr_valid=0.
  - On instr_valid=1: ir<=instr, go to ID.
- ID:
  - Decode ir.
  - Legal opcodes are 0110011, 0010011, 0000011 (f3=010), 0100011 (f3=010), and 1100011 (f3 in {000,001,100,101}).
  - Anything else: trap_cause<=01, go to TRAP.
  - Legal: go to EX.
- EX:
  - Load/store go to MEM; all others go to WB.
  - Wait counter cleared on entry to MEM.
- MEM:
  - MemRead=1 for load, MemWrite=1 for store, held until dReady=1, then go to WB.
  - Counter increments each MEM cycle without dReady.
  - If MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with dReady=0: trap_cause<=10, go to TRAP; strobes drop in TRAP.
  - dReady on the same cycle as the timeout wins (go to WB).
- WB (exactly one cycle, then IF):
  - loadPC=1.
  - RegWrite=1 for R-type, I-ALU and load; 0 for store and branch.
  - MemToReg=1 for load.
  - MemRead=1 for load (holds read data).
  - PCSrc = branch taken.
  - instret increments; wraps modulo 2^CNT_WIDTH.
- Branch taken rule (PCSrc only in WB):
  - BEQ: ALUCtrl=0110 (SUB), taken on Zero.
  - BNE: ALUCtrl=0110, taken on !Zero.
  - BLT: ALUCtrl=0111 (SLT), taken on !Zero.
  - BGE: ALUCtrl=0111, taken on Zero.
- ALUCtrl decode from ir, combinational, valid from ID onward:
  - AND/ANDI 0000, OR/ORI 0001, ADD/ADDI/LW/SW 0010, SUB 0110, SLT/SLTI 0111.
  - SRL/SRLI 1000, SLL/SLLI 1001, SRA/SRAI 1010 (ir[30]=1 selects SRA for both R and I forms), XOR/XORI 1101.
  - Default 0010.
- ALUSrc=1 for I-ALU, load, store; 0 otherwise.
- TRAP:
  - All strobes 0; instret frozen.
  - Held until rst=0.
  - Two-cycle minimum cost for illegal instruction: IF, ID.
- Latency: ALU op 4 cycles, branch 4, load/store 5+wait cycles, given instr_valid=1 in IF.

Decomposition:
- Shared package rv_ctrl_pkg:
  - state encodings;
  - opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH);
  - funct3 constants;
  - ALUCtrl codes;
  - trap_cause codes.
- One sub-module, rv_alu_decode: combinational ir -> ALUCtrl and ALUSrc.
- The FSM, instruction register, wait counter and instret stay in the top.

Test Plan:
1. add x3,x1,x2 = 0x002081B3, instr_valid=1 -> states IF,ID,EX,WB; ALUCtrl=0010; WB: RegWrite=1, loadPC=1, PCSrc=0; instret 0->1.
2. lw x5,8(x1) = 0x0080A283, dReady asserted on 3rd MEM cycle -> MEM lasts 3 cycles with MemRead=1; WB: MemToReg=1, RegWrite=1.
3. sw x5,4(x1) = 0x0050A223, dReady=1 immediately -> one MEM cycle with MemWrite=1; WB: RegWrite=0.
4. bne x1,x2,8 = 0x00209463: Zero=0 -> PCSrc=1 in WB; repeated with Zero=1 -> PCSrc=0; ALUCtrl=0110.
5. 0xFFFFFFFF -> TRAP after ID, trap=1, trap_cause=01, all strobes 0 for 20 cycles; rst=0 pulse returns to IF with instret=0.
6. MEM_TIMEOUT=4, lw with dReady=0 -> TRAP after 4 MEM cycles, trap_cause=10; separate run: rst=0 asserted mid-MEM -> immediate IF, MemRead=0 the same cycle.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// funct3 values, ALU operation codes and trap causes.
// Pure declarations plus one helper function; no logic of its own.
package rv_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IF   = 3'b000,
      ST_ID   = 3'b001,
      ST_EX   = 3'b010,
      ST_MEM  = 3'b011,
      ST_WB   = 3'b100,
      ST_TRAP = 3'b101
   } state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SR      = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_LW      = 3'b010;
   localparam logic [2:0] F3_SW      = 3'b010;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_SRL = 4'b1000;
   localparam logic [3:0] ALU_SLL = 4'b1001;
   localparam logic [3:0] ALU_SRA = 4'b1010;
   localparam logic [3:0] ALU_XOR = 4'b1101;

   localparam logic [1:0] TC_NONE    = 2'b00;
   localparam logic [1:0] TC_ILLEGAL = 2'b01;
   localparam logic [1:0] TC_TIMEOUT = 2'b10;

   // BEQ/BGE are taken on Zero, BNE/BLT on !Zero; f3[0]^f3[2] marks the inverted pair.
   function automatic logic br_taken(input logic [2:0] f3, input logic zero);
      return zero ^ (f3[0] ^ f3[2]);
   endfunction

endpackage

// File: rtl/rv_alu_decode.sv
// Combinational ALU operation and operand-B select decode from the instruction register.
// Zero latency; no handshake.
// Branches compare with SUB (BEQ/BNE) or SLT (BLT/BGE); unknown encodings fall back to ADD.
module rv_alu_decode
   import rv_ctrl_pkg::*;
(
   input  logic [31:0] ir,
   output logic [3:0]  alu_ctrl,
   output logic        alu_src
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic       unused_ir_bits;

   assign opcode         = ir[6:0];
   assign f3             = ir[14:12];
   assign unused_ir_bits = ^{ir[31], ir[29:15], ir[11:7]};

   // Map opcode/funct3/ir[30] to the datapath ALU code and immediate select.
   always_comb begin
      alu_ctrl = ALU_ADD;
      alu_src  = 1'b0;
      case (opcode)
         OP_R, OP_I: begin
            alu_src = (opcode == OP_I);
            case (f3)
               F3_ADD_SUB: alu_ctrl = (opcode == OP_R && ir[30]) ? ALU_SUB : ALU_ADD;
               F3_SLL:     alu_ctrl = ALU_SLL;
               F3_SLT:     alu_ctrl = ALU_SLT;
               F3_XOR:     alu_ctrl = ALU_XOR;
               F3_SR:      alu_ctrl = ir[30] ? ALU_SRA : ALU_SRL;
               F3_OR:      alu_ctrl = ALU_OR;
               F3_AND:     alu_ctrl = ALU_AND;
               default:    alu_ctrl = ALU_ADD;
            endcase
         end
         OP_LOAD, OP_STORE: alu_src = 1'b1;
         OP_BRANCH:         alu_ctrl = f3[2] ? ALU_SLT : ALU_SUB;
         default:           alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl_hs.sv
// Multicycle IF/ID/EX/MEM/WB control FSM with instruction register, memory wait/timeout and trap.
// Latency: ALU/branch 4 cycles, load/store 5 + data-memory wait cycles.
// Stalls in IF until instr_valid and in MEM until dReady; TRAP holds until reset.
module multicycle_ctrl_hs
   import rv_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 32
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [31:0]          instr,
   input  logic                 instr_valid,
   input  logic                 dReady,
   input  logic                 Zero,
   output logic [31:0]          ir,
   output logic [3:0]           ALUCtrl,
   output logic                 ALUSrc,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 MemToReg,
   output logic                 RegWrite,
   output logic                 loadPC,
   output logic                 PCSrc,
   output logic                 trap,
   output logic [1:0]           trap_cause,
   output logic [2:0]           state,
   output logic [CNT_WIDTH-1:0] instret
);

   localparam int WCW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

   state_e               state_q, state_d;
   logic [31:0]          ir_q, ir_d;
   logic [WCW-1:0]       wait_q, wait_d, wait_inc;
   logic [CNT_WIDTH-1:0] instret_q, instret_d;
   logic                 trap_q, trap_d;
   logic [1:0]           cause_q, cause_d;
   logic                 mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, m2r_q, m2r_d;
   logic                 reg_wr_q, reg_wr_d, load_pc_q, load_pc_d, pc_src_q, pc_src_d;

   logic [6:0] opcode;
   logic [2:0] f3;
   logic       is_r, is_i, is_load, is_store, is_branch, legal;

   assign opcode    = ir_q[6:0];
   assign f3        = ir_q[14:12];
   assign is_r      = (opcode == OP_R);
   assign is_i      = (opcode == OP_I);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   // Legal branch funct3 values (000,001,100,101) all have bit 1 clear.
   assign legal     = is_r || is_i || (is_load && f3 == F3_LW) ||
                      (is_store && f3 == F3_SW) || (is_branch && !f3[1]);

   rv_alu_decode u_alu_decode (
      .ir       (ir_q),
      .alu_ctrl (ALUCtrl),
      .alu_src  (ALUSrc)
   );

   // Next state, bookkeeping registers, and strobes registered for the state being entered.
   always_comb begin
      state_d   = state_q;
      ir_d      = ir_q;
      wait_d    = wait_q;
      wait_inc  = wait_q + WCW'(1);
      instret_d = instret_q;
      trap_d    = trap_q;
      cause_d   = cause_q;
      case (state_q)
         ST_IF: if (instr_valid) begin
            ir_d    = instr;
            state_d = ST_ID;
         end
         ST_ID: if (legal) begin
            state_d = ST_EX;
         end else begin
            state_d = ST_TRAP;
            trap_d  = 1'b1;
            cause_d = TC_ILLEGAL;
         end
         ST_EX: if (is_load || is_store) begin
            state_d = ST_MEM;
            wait_d  = '0;
         end else begin
            state_d = ST_WB;
         end
         ST_MEM: if (dReady) begin
            state_d = ST_WB;
         end else begin
            wait_d = wait_inc;
            if (MEM_TIMEOUT != 0 && wait_inc == WCW'(MEM_TIMEOUT)) begin
               state_d = ST_TRAP;
               trap_d  = 1'b1;
               cause_d = TC_TIMEOUT;
            end
         end
         ST_WB: begin
            state_d   = ST_IF;
            instret_d = instret_q + CNT_WIDTH'(1);
         end
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_IF;
      endcase

      // Load keeps MemRead through WB so the read data stays valid for writeback.
      mem_rd_d  = is_load && (state_d == ST_MEM || state_d == ST_WB);
      mem_wr_d  = is_store && (state_d == ST_MEM);
      m2r_d     = is_load && (state_d == ST_WB);
      reg_wr_d  = (is_r || is_i || is_load) && (state_d == ST_WB);
      load_pc_d = (state_d == ST_WB);
      // Zero is sampled in EX, where the datapath computes the comparison.
      pc_src_d  = is_branch && (state_d == ST_WB) && br_taken(f3, Zero);
   end

   // All control state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IF;
         ir_q      <= '0;
         wait_q    <= '0;
         instret_q <= '0;
         trap_q    <= 1'b0;
         cause_q   <= TC_NONE;
         mem_rd_q  <= 1'b0;
         mem_wr_q  <= 1'b0;
         m2r_q     <= 1'b0;
         reg_wr_q  <= 1'b0;
         load_pc_q <= 1'b0;
         pc_src_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         wait_q    <= wait_d;
         instret_q <= instret_d;
         trap_q    <= trap_d;
         cause_q   <= cause_d;
         mem_rd_q  <= mem_rd_d;
         mem_wr_q  <= mem_wr_d;
         m2r_q     <= m2r_d;
         reg_wr_q  <= reg_wr_d;
         load_pc_q <= load_pc_d;
         pc_src_q  <= pc_src_d;
      end
   end

   assign ir         = ir_q;
   assign MemRead    = mem_rd_q;
   assign MemWrite   = mem_wr_q;
   assign MemToReg   = m2r_q;
   assign RegWrite   = reg_wr_q;
   assign loadPC     = load_pc_q;
   assign PCSrc      = pc_src_q;
   assign trap       = trap_q;
   assign trap_cause = cause_q;
   assign state      = state_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Bench for multicycle_ctrl_hs: vector table run through a WB scoreboard,
// plus hand sequences for reset, IF hold, illegal trap, MEM timeout and reset mid-MEM.
module tb_multicycle_ctrl_hs;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] instr;
   logic        instr_valid, dReady, Zero;
   logic [31:0] ir;
   logic [3:0]  ALUCtrl;
   logic        ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, loadPC, PCSrc, trap;
   logic [1:0]  trap_cause;
   logic [2:0]  state;
   logic [31:0] instret;

   int errors = 0;
   int checks = 0;
   int exp_instret = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_hs #(.MEM_TIMEOUT(4), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
      .dReady(dReady), .Zero(Zero), .ir(ir), .ALUCtrl(ALUCtrl), .ALUSrc(ALUSrc),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
      .RegWrite(RegWrite), .loadPC(loadPC), .PCSrc(PCSrc), .trap(trap),
      .trap_cause(trap_cause), .state(state), .instret(instret)
   );

   typedef struct {
      logic [31:0] instr;
      logic        zero;
      int          wait_n;  // MEM cycles before dReady
      logic [3:0]  alu;
      logic        src, rw, m2r, pcs;
      int          mem;     // 0 none, 1 load, 2 store
      int          cycles;  // IF through WB
   } vec_t;

   typedef struct {
      logic [3:0] alu;
      logic       src, rw, m2r, pcs, mrd;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   function automatic vec_t mk(input logic [31:0] i, input logic z, input int w,
                               input logic [3:0] a, input logic s, input logic r,
                               input logic m, input logic p, input int mm, input int c);
      vec_t v;
      v.instr = i; v.zero = z; v.wait_n = w; v.alu = a; v.src = s; v.rw = r;
      v.m2r = m; v.pcs = p; v.mem = mm; v.cycles = c;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      exp_instret = 0;
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      exp_t e, g;
      int   n, memc;
      bit   done;
      e.alu = v.alu; e.src = v.src; e.rw = v.rw; e.m2r = v.m2r; e.pcs = v.pcs;
      e.mrd = (v.mem == 1);
      sb.push_back(e);
      instr = v.instr; instr_valid = 1'b1; Zero = v.zero; dReady = 1'b0;
      n = 1; memc = 0; done = 0;
      for (int c = 0; c < 40 && !done; c++) begin
         step();
         instr_valid = 1'b0;
         if (state == 3'd0) begin
            done = 1;
         end else begin
            n++;
            if (state == 3'd3) begin
               memc++;
               chk("mem_rd_in_mem", 32'(MemRead), 32'(v.mem == 1));
               chk("mem_wr_in_mem", 32'(MemWrite), 32'(v.mem == 2));
               dReady = (memc == v.wait_n + 1);
            end else begin
               dReady = 1'b0;
            end
            if (state == 3'd4) begin
               if (sb.size() == 0) begin
                  errors++; checks++;
                  $display("FAIL wb_without_expect: got WB expected none");
               end else begin
                  g = sb.pop_front();
                  chk("alu_ctrl", 32'(ALUCtrl), 32'(g.alu));
                  chk("alu_src", 32'(ALUSrc), 32'(g.src));
                  chk("reg_write", 32'(RegWrite), 32'(g.rw));
                  chk("mem_to_reg", 32'(MemToReg), 32'(g.m2r));
                  chk("pc_src", 32'(PCSrc), 32'(g.pcs));
                  chk("wb_mem_rd", 32'(MemRead), 32'(g.mrd));
                  chk("wb_mem_wr", 32'(MemWrite), 32'd0);
                  chk("load_pc", 32'(loadPC), 32'd1);
               end
            end
         end
      end
      if (!done) begin
         errors++; checks++;
         $display("FAIL return_to_if: instr %08h state %0d after 40 cycles", v.instr, state);
      end
      exp_instret++;
      chk("cycles", 32'(n), 32'(v.cycles));
      chk("mem_cycles", 32'(memc), (v.mem != 0) ? 32'(v.wait_n + 1) : 32'd0);
      chk("instret", instret, 32'(exp_instret));
      chk("ir_latched", ir, v.instr);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0; instr = '0; instr_valid = 1'b0; dReady = 1'b0; Zero = 1'b0;
      //        instr         Z  w  alu   src rw m2r pcs mem cyc
      vecs.push_back(mk(32'h002081B3, 0, 0, 4'h2, 0, 1, 0, 0, 0, 4)); // add
      vecs.push_back(mk(32'h0080A283, 0, 2, 4'h2, 1, 1, 1, 0, 1, 7)); // lw, 3 MEM cycles
      vecs.push_back(mk(32'h0050A223, 0, 0, 4'h2, 1, 0, 0, 0, 2, 5)); // sw
      vecs.push_back(mk(32'h00209463, 0, 0, 4'h6, 0, 0, 0, 1, 0, 4)); // bne taken
      vecs.push_back(mk(32'h00209463, 1, 0, 4'h6, 0, 0, 0, 0, 0, 4)); // bne not taken
      vecs.push_back(mk(32'h00208463, 1, 0, 4'h6, 0, 0, 0, 1, 0, 4)); // beq taken
      vecs.push_back(mk(32'h0020C463, 0, 0, 4'h7, 0, 0, 0, 1, 0, 4)); // blt taken
      vecs.push_back(mk(32'h0020D463, 1, 0, 4'h7, 0, 0, 0, 1, 0, 4)); // bge taken
      vecs.push_back(mk(32'h0020D463, 0, 0, 4'h7, 0, 0, 0, 0, 0, 4)); // bge not taken
      vecs.push_back(mk(32'h402081B3, 0, 0, 4'h6, 0, 1, 0, 0, 0, 4)); // sub
      vecs.push_back(mk(32'h4020D1B3, 0, 0, 4'hA, 0, 1, 0, 0, 0, 4)); // sra
      vecs.push_back(mk(32'h4030D193, 0, 0, 4'hA, 1, 1, 0, 0, 0, 4)); // srai
      vecs.push_back(mk(32'h0020D1B3, 0, 0, 4'h8, 0, 1, 0, 0, 0, 4)); // srl
      vecs.push_back(mk(32'h002091B3, 0, 0, 4'h9, 0, 1, 0, 0, 0, 4)); // sll
      vecs.push_back(mk(32'h0020F1B3, 0, 0, 4'h0, 0, 1, 0, 0, 0, 4)); // and
      vecs.push_back(mk(32'h0020E1B3, 0, 0, 4'h1, 0, 1, 0, 0, 0, 4)); // or
      vecs.push_back(mk(32'h0050C193, 0, 0, 4'hD, 1, 1, 0, 0, 0, 4)); // xori
      vecs.push_back(mk(32'h0050A193, 0, 0, 4'h7, 1, 1, 0, 0, 0, 4)); // slti
      vecs.push_back(mk(32'h0080A283, 0, 3, 4'h2, 1, 1, 1, 0, 1, 8)); // lw, dReady on timeout cycle

      // Reset values while held in reset.
      @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_ir", ir, 32'd0);
      chk("rst_instret", instret, 32'd0);
      chk("rst_trap", {30'd0, trap_cause}, 32'd0);
      chk("rst_trap_flag", 32'(trap), 32'd0);
      chk("rst_alu", {28'd0, ALUCtrl}, 32'h2);
      chk("rst_strobes", {25'd0, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, loadPC, PCSrc}, 32'd0);
      rst = 1'b1;

      // IF holds while instr_valid is low.
      for (int i = 0; i < 3; i++) begin
         step();
         chk("if_hold", 32'(state), 32'd0);
      end

      foreach (vecs[i]) run_vec(vecs[i]);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      // Illegal instruction: IF, ID, then sticky TRAP.
      instr = 32'hFFFFFFFF; instr_valid = 1'b1;
      step();
      instr_valid = 1'b0;
      chk("ill_id", 32'(state), 32'd1);
      step();
      chk("ill_trap_state", 32'(state), 32'd5);
      chk("ill_trap", 32'(trap), 32'd1);
      chk("ill_cause", {30'd0, trap_cause}, 32'd1);
      for (int i = 0; i < 20; i++) begin
         step();
         chk("trap_hold", {26'd0, state, MemRead, MemWrite, RegWrite},
             {26'd0, 3'd5, 3'd0});
         chk("trap_quiet", {29'd0, MemToReg, loadPC, PCSrc}, 32'd0);
      end
      chk("trap_instret", instret, 32'(exp_instret));
      do_reset();
      chk("post_trap_state", 32'(state), 32'd0);
      chk("post_trap_instret", instret, 32'd0);
      chk("post_trap_flag", {29'd0, trap, trap_cause}, 32'd0);

      // Load with byte width (f3=000) is not supported.
      instr = 32'h00008283; instr_valid = 1'b1;
      step(); instr_valid = 1'b0;
      step();
      chk("lb_trap", {29'd0, trap, trap_cause}, 32'b101);
      do_reset();

      // Data memory timeout after 4 MEM cycles.
      begin
         int memc;
         bit seen;
         memc = 0; seen = 0;
         instr = 32'h0080A283; instr_valid = 1'b1; dReady = 1'b0;
         for (int c = 0; c < 30 && !seen; c++) begin
            step();
            instr_valid = 1'b0;
            if (state == 3'd3) memc++;
            if (state == 3'd5) seen = 1;
         end
         chk("timeout_reached", 32'(seen), 32'd1);
         chk("timeout_mem_cycles", 32'(memc), 32'd4);
         chk("timeout_cause", {29'd0, trap, trap_cause}, 32'b110);
         chk("timeout_strobe", {30'd0, MemRead, RegWrite}, 32'd0);
      end
      do_reset();

      // Asynchronous reset in the middle of a MEM wait.
      instr = 32'h0080A283; instr_valid = 1'b1; dReady = 1'b0;
      step(); instr_valid = 1'b0;
      step(); step(); step();
      chk("mid_mem_state", 32'(state), 32'd3);
      chk("mid_mem_rd", 32'(MemRead), 32'd1);
      rst = 1'b0;
      #1;
      chk("async_state", 32'(state), 32'd0);
      chk("async_mem_rd", 32'(MemRead), 32'd0);
      #1;
      rst = 1'b1;
      step();
      chk("after_async_if", 32'(state), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
